// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for the IF/ID instruction queue.
// The queue side uses the slave modport. The fetch/decode side uses master.
interface if_id_queue_if #(
  parameter int INST_W = 32,
  parameter int PC_W   = 64,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic [INST_W-1:0] in_inst;
  logic [PC_W-1:0]   in_pc;
  logic              in_ready;
  logic              out_valid;
  logic [INST_W-1:0] out_inst;
  logic [PC_W-1:0]   out_pc;
  logic              out_ready;
  logic              flush;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_inst, in_pc, out_ready, flush,
    input  in_ready, out_valid, out_inst, out_pc, count
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready, flush,
    output in_ready, out_valid, out_inst, out_pc, count
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: a DEPTH-entry circular FIFO of {inst, pc} pairs.
// All outputs come from registered state only, so nothing on the input side
// reaches the outputs in the same cycle. Flush clears the pointers and the
// occupancy but leaves the storage alone. The storage has no reset because
// only entries below count are ever observed.
// DEPTH must be a power of two and at least 2, so that the pointers wrap
// naturally at $clog2(DEPTH) bits.
module if_id_queue #(
  parameter int INST_W = 32,
  parameter int PC_W   = 64,
  parameter int DEPTH  = 4
) (
  input  logic          clk,
  input  logic          reset,
  if_id_queue_if.slave  q_if
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [PC_W-1:0]   pc_mem_q   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              in_ready;
  logic              out_valid;
  logic              push;
  logic              pop;
  logic              wr_en;

  // Handshake flags and the bubble-forced head outputs, from state only
  always_comb begin
    in_ready       = (count_q != CNT_W'(DEPTH));
    out_valid      = (count_q != '0);
    push           = q_if.in_valid & in_ready;
    pop            = out_valid & q_if.out_ready;
    wr_en          = push & ~q_if.flush;
    q_if.in_ready  = in_ready;
    q_if.out_valid = out_valid;
    q_if.count     = count_q;
    q_if.out_inst  = out_valid ? inst_mem_q[rd_ptr_q] : '0;
    q_if.out_pc    = out_valid ? pc_mem_q[rd_ptr_q]   : '0;
  end

  // Next pointer and occupancy; flush overrides both push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q_if.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; written on an accepted, non-flushed push only
  always_ff @(posedge clk) begin
    if (wr_en) begin
      inst_mem_q[wr_ptr_q] <= q_if.in_inst;
      pc_mem_q[wr_ptr_q]   <= q_if.in_pc;
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Testbench for if_id_queue. Two instances share the same stimulus:
// a = DEPTH 4, INST_W 32, PC_W 64
// b = DEPTH 2, INST_W 16, PC_W 32
module tb_if_id_queue;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;
  bit          chk_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_id_queue_if #(.INST_W(32), .PC_W(64), .DEPTH(4)) a_if ();
  if_id_queue_if #(.INST_W(16), .PC_W(32), .DEPTH(2)) b_if ();

  assign a_if.in_valid  = in_valid;
  assign a_if.in_inst   = in_inst;
  assign a_if.in_pc     = in_pc;
  assign a_if.out_ready = out_ready;
  assign a_if.flush     = flush;
  assign b_if.in_valid  = in_valid;
  assign b_if.in_inst   = in_inst[15:0];
  assign b_if.in_pc     = in_pc[31:0];
  assign b_if.out_ready = out_ready;
  assign b_if.flush     = flush;

  if_id_queue #(.INST_W(32), .PC_W(64), .DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .q_if(a_if.slave));
  if_id_queue #(.INST_W(16), .PC_W(32), .DEPTH(2)) dut_b (
    .clk(clk), .reset(reset), .q_if(b_if.slave));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return {pc[15:0] ^ 16'hC3C3, pc[15:0] ^ 16'h5A5A};
  endfunction

  // Reference model: each queue is a list of {inst, pc}, bounded by its depth
  logic [95:0] qa[$];
  logic [95:0] qb[$];
  bit pop_a, push_a, pop_b, push_b;

  always @(posedge clk or negedge reset) begin
    if (!reset || flush) begin
      qa.delete();
      qb.delete();
    end else begin
      pop_a  = (qa.size() != 0) && out_ready;
      push_a = in_valid && (qa.size() < 4);
      pop_b  = (qb.size() != 0) && out_ready;
      push_b = in_valid && (qb.size() < 2);
      if (pop_a)  void'(qa.pop_front());
      if (push_a) qa.push_back({in_inst, in_pc});
      if (pop_b)  void'(qb.pop_front());
      if (push_b) qb.push_back({in_inst, in_pc});
    end
  end

  logic [95:0] ha, hb;
  always @(negedge clk) begin
    if (chk_en) begin
      ha = (qa.size() != 0) ? qa[0] : 96'h0;
      hb = (qb.size() != 0) ? qb[0] : 96'h0;
      chk("model_a.count",     64'(a_if.count),     64'(qa.size()));
      chk("model_a.out_valid", 64'(a_if.out_valid), 64'(qa.size() != 0));
      chk("model_a.in_ready",  64'(a_if.in_ready),  64'(qa.size() < 4));
      chk("model_a.out_pc",    a_if.out_pc,         ha[63:0]);
      chk("model_a.out_inst",  64'(a_if.out_inst),  64'(ha[95:64]));
      chk("model_b.count",     64'(b_if.count),     64'(qb.size()));
      chk("model_b.out_valid", 64'(b_if.out_valid), 64'(qb.size() != 0));
      chk("model_b.in_ready",  64'(b_if.in_ready),  64'(qb.size() < 2));
      chk("model_b.out_pc",    64'(b_if.out_pc),    64'(hb[31:0]));
      chk("model_b.out_inst",  64'(b_if.out_inst),  64'(hb[79:64]));
    end
  end

  typedef struct {
    logic        iv;
    logic [63:0] pc;
    logic        ordy;
    logic        fl;
    int          cnt;
    logic        ovld;
    logic        irdy;
    logic [63:0] opc;
  } vec_t;

  vec_t vecs[18];

  task automatic chk_idle_a(input string nm);
    chk({nm, ".count_a"},    64'(a_if.count),     64'd0);
    chk({nm, ".ovld_a"},     64'(a_if.out_valid), 64'd0);
    chk({nm, ".irdy_a"},     64'(a_if.in_ready),  64'd1);
    chk({nm, ".opc_a"},      a_if.out_pc,         64'd0);
    chk({nm, ".oinst_a"},    64'(a_if.out_inst),  64'd0);
    chk({nm, ".count_b"},    64'(b_if.count),     64'd0);
    chk({nm, ".ovld_b"},     64'(b_if.out_valid), 64'd0);
    chk({nm, ".opc_b"},      64'(b_if.out_pc),    64'd0);
  endtask

  initial begin
    // Fill/drain, full with push+pop, flush with push
    vecs[0]  = '{1'b1, 64'h0,  1'b0, 1'b0, 1, 1'b1, 1'b1, 64'h0};
    vecs[1]  = '{1'b1, 64'h4,  1'b0, 1'b0, 2, 1'b1, 1'b1, 64'h0};
    vecs[2]  = '{1'b1, 64'h8,  1'b0, 1'b0, 3, 1'b1, 1'b1, 64'h0};
    vecs[3]  = '{1'b1, 64'hC,  1'b0, 1'b0, 4, 1'b1, 1'b0, 64'h0};
    vecs[4]  = '{1'b0, 64'h0,  1'b1, 1'b0, 3, 1'b1, 1'b1, 64'h4};
    vecs[5]  = '{1'b0, 64'h0,  1'b1, 1'b0, 2, 1'b1, 1'b1, 64'h8};
    vecs[6]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1, 1'b1, 1'b1, 64'hC};
    vecs[7]  = '{1'b0, 64'h0,  1'b1, 1'b0, 0, 1'b0, 1'b1, 64'h0};
    vecs[8]  = '{1'b1, 64'h10, 1'b0, 1'b0, 1, 1'b1, 1'b1, 64'h10};
    vecs[9]  = '{1'b1, 64'h14, 1'b0, 1'b0, 2, 1'b1, 1'b1, 64'h10};
    vecs[10] = '{1'b1, 64'h18, 1'b0, 1'b0, 3, 1'b1, 1'b1, 64'h10};
    vecs[11] = '{1'b1, 64'h1C, 1'b0, 1'b0, 4, 1'b1, 1'b0, 64'h10};
    vecs[12] = '{1'b1, 64'h20, 1'b1, 1'b0, 3, 1'b1, 1'b1, 64'h14};
    vecs[13] = '{1'b1, 64'h20, 1'b0, 1'b0, 4, 1'b1, 1'b0, 64'h14};
    vecs[14] = '{1'b0, 64'h0,  1'b1, 1'b0, 3, 1'b1, 1'b1, 64'h18};
    vecs[15] = '{1'b1, 64'h40, 1'b0, 1'b1, 0, 1'b0, 1'b1, 64'h0};
    vecs[16] = '{1'b0, 64'h0,  1'b1, 1'b0, 0, 1'b0, 1'b1, 64'h0};
    vecs[17] = '{1'b0, 64'h0,  1'b1, 1'b0, 0, 1'b0, 1'b1, 64'h0};

    // Reset state, checked before any clock edge
    #3;
    chk_idle_a("reset");
    chk("reset.irdy_b", 64'(b_if.in_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b1;
    chk_en = 1'b1;

    // Table-driven vectors on instance a (instance b is checked by the model)
    for (int i = 0; i < 18; i++) begin
      in_valid  = vecs[i].iv;
      in_pc     = vecs[i].pc;
      in_inst   = inst_of(vecs[i].pc);
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      @(negedge clk);
      chk($sformatf("vec%0d.count", i), 64'(a_if.count),     64'(vecs[i].cnt));
      chk($sformatf("vec%0d.ovld", i),  64'(a_if.out_valid), 64'(vecs[i].ovld));
      chk($sformatf("vec%0d.irdy", i),  64'(a_if.in_ready),  64'(vecs[i].irdy));
      chk($sformatf("vec%0d.opc", i),   a_if.out_pc,         vecs[i].opc);
      chk($sformatf("vec%0d.oinst", i), 64'(a_if.out_inst),
          vecs[i].ovld ? 64'(inst_of(vecs[i].opc)) : 64'd0);
    end
    flush = 1'b0;

    // Streaming across pointer wrap: occupancy holds at 1 on both depths
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_pc   = 64'h200 + 64'(4 * k);
      in_inst = inst_of(in_pc);
      @(negedge clk);
      chk($sformatf("stream%0d.count_a", k), 64'(a_if.count),  64'd1);
      chk($sformatf("stream%0d.count_b", k), 64'(b_if.count),  64'd1);
      chk($sformatf("stream%0d.opc_a", k),   a_if.out_pc,      64'h200 + 64'(4 * k));
      chk($sformatf("stream%0d.opc_b", k),   64'(b_if.out_pc), 64'h200 + 64'(4 * k));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk_idle_a("stream_drain");

    // Asynchronous reset with entries queued
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 64'h300; in_inst = inst_of(in_pc);
    @(negedge clk);
    in_pc     = 64'h304; in_inst = inst_of(in_pc);
    @(negedge clk);
    in_valid  = 1'b0;
    chk("areset.pre_count_a", 64'(a_if.count), 64'd2);
    chk("areset.pre_count_b", 64'(b_if.count), 64'd2);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_idle_a("areset.now");
    @(posedge clk);
    #2;
    chk_idle_a("areset.held");
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_pc    = 64'h100; in_inst = inst_of(in_pc);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("areset.first_count_a", 64'(a_if.count), 64'd1);
    chk("areset.first_opc_a",   a_if.out_pc,     64'h100);
    chk("areset.first_opc_b",   64'(b_if.out_pc), 64'h100);
    @(negedge clk);
    chk_idle_a("areset.after");

    // Randomized traffic against the model, alternating congestion phases
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 99) < 65);
      out_ready = ($urandom_range(0, 99) < (((i / 100) % 2 == 0) ? 30 : 75));
      flush     = ($urandom_range(0, 99) < 4);
      in_pc     = {$urandom, $urandom};
      in_inst   = $urandom;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter INST_W, default 32, instruction width in bits.
REQ-002 SHALL have parameter PC_W, default 64, fetch address width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-006 SHALL have port in_valid, input, 1, fetch presents an entry.
REQ-007 SHALL have port in_inst, input, INST_W, fetched instruction.
REQ-008 SHALL have port in_pc, input, PC_W, address of in_inst.
REQ-009 SHALL have port in_ready, output, 1, queue accepts an entry this cycle.
REQ-010 SHALL have port out_valid, output, 1, head entry available to decode.
REQ-011 SHALL have port out_inst, output, INST_W, head instruction.
REQ-012 SHALL have port out_pc, output, PC_W, head address.
REQ-013 SHALL have port out_ready, input, 1, decode consumes the head this cycle.
REQ-014 SHALL have port flush, input, 1, discard all entries (branch redirect).
REQ-015 SHALL have port count, output, $clog2(DEPTH+1), number of occupied entries.

Function
REQ-016 SHALL implement push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-017 SHALL drive in_ready = (count != DEPTH), with no combinational path from out_ready or flush.
REQ-018 SHALL drive out_valid = (count != 0), with no combinational path from any input.
REQ-019 SHALL give latency of exactly one cycle: an entry pushed at edge N is visible on out_* after edge N; no same-cycle input-to-output bypass.
REQ-020 SHALL drive out_inst and out_pc from the head entry when out_valid=1 and force them to all-zero when out_valid=0 (bubble).
REQ-021 SHALL deliver entries in strict FIFO order, with instruction and PC of each entry kept paired.
REQ-022 SHALL use DEPTH-entry storage with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH with no lost or duplicated entry.
REQ-023 SHALL update count by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
REQ-024 SHALL, when full, allow a simultaneous pop while in_ready stays 0 that cycle; the freed slot is accepted on the next cycle.
REQ-025 SHALL, when empty, take no pop action (out_valid=0 and out_ready ignored).
REQ-026 SHALL give flush=1 priority over push and pop: at the next edge count=0, pointers=0, and any same-cycle push is dropped.
REQ-027 SHALL make out_valid=0 and in_ready=1 on the cycle after a flush.
REQ-028 SHALL NOT reset entry storage contents on flush; only pointers and count are cleared.

Reset
REQ-029 SHALL, while reset=0 and regardless of clk, force count=0 and pointers=0, giving out_valid=0, out_inst=0, out_pc=0, and in_ready=1.
REQ-030 SHALL, if reset is asserted mid-operation, lose all queued entries, with no entry delivered after reset deasserts.
REQ-031 SHALL accept the first push at the first rising edge after reset returns to 1.

Verification
REQ-032 SHALL cover fill and drain (DEPTH=4): push pc 0x0,0x4,0x8,0xC with out_ready=0 -> count=4, in_ready=0; then out_ready=1 -> out_pc 0x0,0x4,0x8,0xC on consecutive cycles, then out_valid=0 with out_inst=0.
REQ-033 SHALL cover full with simultaneous push and pop: count=4, in_valid=1, out_ready=1 -> push ignored, count=3; the next cycle push accepted, count=4.
REQ-034 SHALL cover streaming: continuous in_valid=1 and out_ready=1 for 20 cycles -> count holds at 1 after the first cycle, and out_pc sequence equals in_pc sequence delayed by one cycle across pointer wrap.
REQ-035 SHALL cover flush with push: count=3, flush=1 and in_valid=1 (pc 0x40) -> next cycle count=0, out_valid=0, and 0x40 is never emitted.
REQ-036 SHALL cover asynchronous reset: count=2, reset driven to 0 between clock edges -> out_valid=0 and count=0 immediately; after release, push of pc 0x100 appears alone at output.
REQ-037 SHALL cover parameter sweep: DEPTH=2, INST_W=16, PC_W=32 -> REQ-032 to REQ-035 pass with scaled values.
